// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and oversample rate.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam int unsigned OVERSAMPLE = 16;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake of a first-word-fall-through FIFO.
interface fifo_uart_tx_if #(
  parameter int DataBits = 8
) ();
  logic                empty;
  logic [DataBits-1:0] rdata;
  logic                rd;

  modport master (input empty, input rdata, output rd);
  modport slave  (output empty, output rdata, input rd);
endinterface

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one tick every dvsr_i+1 clocks, held cleared while clr_i is high.
module uart_baud_gen #(
  parameter int DvsrBits = 11
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic [DvsrBits-1:0] dvsr_i,
  output logic                tick_o
);

  logic [DvsrBits-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || cnt_q == dvsr_i) cnt_d = '0;
    else                          cnt_d = cnt_q + DvsrBits'(1);
  end

  assign tick_o = !clr_i && (cnt_q == dvsr_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a FWFT FIFO and serializes them
// as start, data (LSB first), optional parity and stop bits.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DataBits   = 8,
  parameter int ParityMode = 0,
  parameter int StopBits   = 1,
  parameter int DvsrBits   = 11
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DvsrBits-1:0] dvsr_i,
  fifo_uart_tx_if.master      fifo,
  output logic                tx_o,
  output logic                busy_o,
  output logic                done_tick_o
);

  localparam logic [4:0] TickLastBit  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] TickLastStop = 5'(OVERSAMPLE * StopBits - 1);
  localparam logic [3:0] BitLast      = 4'(DataBits - 1);

  tx_state_e           state_q, state_d;
  logic [DataBits-1:0] shreg_q, shreg_d;
  logic [DataBits-1:0] word_q, word_d;
  logic [DvsrBits-1:0] dvsr_q, dvsr_d;
  logic [4:0]          tick_cnt_q, tick_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic                tx_q, tx_d;
  logic                tick, tick_last, baud_clr, pop, done, par_bit;

  assign baud_clr = (state_q == IDLE);

  uart_baud_gen #(.DvsrBits(DvsrBits)) u_baud (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (baud_clr),
    .dvsr_i (dvsr_q),
    .tick_o (tick)
  );

  // Parity always comes from the word as popped, never from the shifted copy.
  assign par_bit = (^word_q) ^ (ParityMode == PARITY_ODD);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    word_d     = word_q;
    dvsr_d     = dvsr_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    pop        = 1'b0;
    done       = 1'b0;
    tick_last  = (state_q == STOP) ? (tick_cnt_q == TickLastStop)
                                   : (tick_cnt_q == TickLastBit);

    if (state_q != IDLE && tick)
      tick_cnt_d = tick_last ? 5'd0 : tick_cnt_q + 5'd1;

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!fifo.empty) begin
          pop     = 1'b1;
          shreg_d = fifo.rdata;
          word_d  = fifo.rdata;
          dvsr_d  = dvsr_i;
          state_d = START;
        end
      end
      START: if (tick && tick_last) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (tick && tick_last) begin
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == BitLast)
          state_d = (ParityMode != PARITY_NONE) ? PARITY : STOP;
      end
      PARITY: if (tick && tick_last) state_d = STOP;
      STOP: if (tick && tick_last) begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so tx_o falls the cycle after the pop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      word_q     <= '0;
      dvsr_q     <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      word_q     <= word_d;
      dvsr_q     <= dvsr_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
    end
  end

  assign fifo.rd     = pop && !rst_i;
  assign tx_o        = tx_q;
  assign busy_o      = (state_q != IDLE);
  assign done_tick_o = done;

endmodule
